conv1d_index_sequencer: RTL and testbench
=========================================

# conv1d_index_sequencer

Upstream controller for the Conv1D datapath. It sequences one convolution job through five phases: file preload, L0 fill, compute, pipeline drain and writeback. In each phase it drives the memory and L0 indices, the per-stream L0 status codes, the file load/write flags and `L0_Data_Is_Ready`. These outputs feed the memory/L0 enable-and-address generator directly. All outputs are registered.

## Interface
Parameters:
- `Weight_Addr_Width`, 2: SRAM weight address bits.
- `Input_Addr_Width`, 4: SRAM input address bits.
- `Output_Addr_Width`, 3: SRAM output address bits.
- `L0_Weight_Addr_Width`, 2: L0 weight address bits.
- `L0_Input_Addr_Width`, 4: L0 input address bits.
- `L0_Output_Addr_Width`, 3: L0 output address bits.
- `Weight_Nums`, 4: number of kernel taps.
- `Output_Nums`, 8: number of output points.
- `Input_Nums`, `Output_Nums + Weight_Nums - 1` (11 with defaults): number of input points.
- `Nums_Pipeline_Stages`, 4: MAC pipeline depth.
- `Pipeline_Tail`, `Nums_Pipeline_Stages - 1`: number of drain cycles.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `Start`, in, 1: one-cycle job request.
- `Preload_Output`, in, 1: sampled with `Start`; when 1, the output SRAM is also loaded from file.
- `Weight_Loading_From_File`, `Input_Loading_From_File`, `Output_Loading_From_File`, out, 1 each: file preload flags.
- `Output_Writing_To_File`, out, 1: writeback flag.
- `Mem_Weight_Index`, out, `Weight_Addr_Width+1`: SRAM weight index.
- `Mem_Input_Index`, out, `Input_Addr_Width+1`: SRAM input index.
- `Mem_Output_Index`, out, `Output_Addr_Width+1`: SRAM output index.
- `L0_Weight_Index`, `L0_Input_Index`, `L0_Output_Index`, out, `L0_*_Addr_Width+1`: L0 indices.
- `L0_Weight_Status`, `L0_Input_Status`, `L0_Output_Status`, out, 2 each: status code per stream. 00 = idle/file, 01 = filling L0, 10 = L0 loaded.
- `L0_Data_Is_Ready`, out, 1: high when a MAC operand is valid this cycle.
- `Busy`, out, 1: high from the cycle after an accepted `Start` until `Done`.
- `Done`, out, 1: one-cycle completion pulse.

## Operation
- States: IDLE → FILE → FILL → COMPUTE → DRAIN → WB → FIN → IDLE.
- Reset value: every output 0, state IDLE.
- **IDLE.** All outputs are 0. `Start=1` captures `Preload_Output` and moves to FILE. `Start` is ignored in every other state.
- **FILE.**
  - A counter `f` runs from 0 upward. `Mem_Weight_Index`, `Mem_Input_Index` and `Mem_Output_Index` all equal `f`.
  - `Weight_Loading_From_File` is 1 while `f < Weight_Nums`. `Input_Loading_From_File` is 1 while `f < Input_Nums`.
  - `Output_Loading_From_File` is 1 while `f < Output_Nums` and only if `Preload_Output` was captured as 1.
  - Once a stream's flag has dropped, that stream's index holds 0.
  - All statuses are 00.
  - FILE exits after `max(Weight_Nums, Input_Nums, Output_Nums)` cycles.
- **FILL.**
  - A counter `k` runs from 0 upward. Each stream X has depth D_X (`Weight_Nums`, `Input_Nums` or `Output_Nums`).
  - While `k < D_X + 2`:
    - `L0_X_Status` = 01.
    - `Mem_X_Index` = `k + 2`, so the downstream stage's `Index - 2` read address equals `k`.
    - `L0_X_Index` = 0 for `k < 2`, otherwise `k - 2`. The 2-cycle offset covers SRAM latency plus downstream registering.
  - After that, `L0_X_Status` = 10 and both of stream X's indices are 0.
  - FILL exits when every stream reaches status 10. With defaults this is 13 cycles.
- **COMPUTE.**
  - Nested counters: `o` (outer, 0..`Output_Nums-1`) and `w` (inner, 0..`Weight_Nums-1`).
  - Outputs: `L0_Weight_Index=w`, `L0_Input_Index=o+w`, `L0_Output_Index=o`, `L0_Data_Is_Ready=1`.
  - All statuses are 10. Lasts `Weight_Nums*Output_Nums` cycles.
- **DRAIN.** `L0_Data_Is_Ready=0`. L0 indices hold their final values. Lasts `Pipeline_Tail` cycles.
- **WB.**
  - `Output_Writing_To_File=1`.
  - `Mem_Output_Index` runs 0..`Output_Nums-1`.
  - `L0_Output_Status=00`; the other statuses stay 10.
  - Lasts `Output_Nums` cycles.
- **FIN.** `Done=1` and `Busy=0` for one cycle. All outputs return to 0. Next state is IDLE.
- Width rules:
  - `o+w` must not exceed `2^L0_Input_Addr_Width - 1`.
  - Index widths carry one spare bit so a terminal count is representable.
  - Counters never wrap within a job.
- Boundary cases:
  - `rst_n` low at any cycle forces IDLE and all outputs to 0 immediately (asynchronous).
  - A `Start` coincident with FIN is ignored.

## Timing
- `Start` is sampled at edge 0. FILE outputs are valid from edge 1.
- Each state's first outputs appear on the edge after the previous state's last cycle. There are no bubble cycles between states.
- Job length with defaults: FILE 11 + FILL 13 + COMPUTE 32 + DRAIN 3 + WB 8 + FIN 1 = 68 cycles. `Done` asserts at edge 68 after `Start`.
- `L0_Data_Is_Ready` is high for exactly 32 consecutive cycles.

## Test plan
- Reset, then `Start` with `Preload_Output=1`:
  - FILE: weight flag high 4 cycles, input flag 11, output flag 8; indices count 0..10.
  - `Done` asserts at cycle 68; `Busy` is high for cycles 1–67.
- `Start` with `Preload_Output=0`: `Output_Loading_From_File` stays 0 for the whole job; every other count is unchanged.
- FILL check:
  - `L0_Weight_Status` is 01 for 6 cycles, then 10.
  - `L0_Input_Status` is 01 for 13 cycles.
  - Checkpoints: at k=5, `Mem_Input_Index=7` and `L0_Input_Index=3`.
- COMPUTE check:
  - Sequence (w, o+w, o) runs (0,0,0), (1,1,0) … (3,10,7).
  - `L0_Data_Is_Ready` is high 32 cycles, then low 3 cycles (DRAIN).
  - WB: `Mem_Output_Index` runs 0..7 with `Output_Writing_To_File=1`.
- `Start` pulses during COMPUTE and on the FIN cycle: both are ignored; exactly one `Done` is produced.
- `rst_n` driven low mid-COMPUTE (o=3, w=2): all outputs are 0 asynchronously. After release, a new `Start` runs a full 68-cycle job.

Source files
------------

// File: rtl/conv1d_index_sequencer.sv
// Sequences one Conv1D job through file preload, L0 fill, compute, drain and writeback.
// Outputs are registered from the next-state view, so each phase's first values appear on the entering edge.
module conv1d_index_sequencer #(
   parameter int Weight_Addr_Width    = 2,
   parameter int Input_Addr_Width     = 4,
   parameter int Output_Addr_Width    = 3,
   parameter int L0_Weight_Addr_Width = 2,
   parameter int L0_Input_Addr_Width  = 4,
   parameter int L0_Output_Addr_Width = 3,
   parameter int Weight_Nums          = 4,
   parameter int Output_Nums          = 8,
   parameter int Input_Nums           = Output_Nums + Weight_Nums - 1,
   parameter int Nums_Pipeline_Stages = 4,
   parameter int Pipeline_Tail        = Nums_Pipeline_Stages - 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              Start,
   input  logic                              Preload_Output,
   output logic                              Weight_Loading_From_File,
   output logic                              Input_Loading_From_File,
   output logic                              Output_Loading_From_File,
   output logic                              Output_Writing_To_File,
   output logic [Weight_Addr_Width:0]        Mem_Weight_Index,
   output logic [Input_Addr_Width:0]         Mem_Input_Index,
   output logic [Output_Addr_Width:0]        Mem_Output_Index,
   output logic [L0_Weight_Addr_Width:0]     L0_Weight_Index,
   output logic [L0_Input_Addr_Width:0]      L0_Input_Index,
   output logic [L0_Output_Addr_Width:0]     L0_Output_Index,
   output logic [1:0]                        L0_Weight_Status,
   output logic [1:0]                        L0_Input_Status,
   output logic [1:0]                        L0_Output_Status,
   output logic                              L0_Data_Is_Ready,
   output logic                              Busy,
   output logic                              Done
);
   localparam int MW = Weight_Addr_Width + 1;
   localparam int MI = Input_Addr_Width + 1;
   localparam int MO = Output_Addr_Width + 1;
   localparam int LW = L0_Weight_Addr_Width + 1;
   localparam int LI = L0_Input_Addr_Width + 1;
   localparam int LO = L0_Output_Addr_Width + 1;
   localparam int MAX_N = (Input_Nums > Weight_Nums)
                          ? ((Input_Nums > Output_Nums) ? Input_Nums : Output_Nums)
                          : ((Weight_Nums > Output_Nums) ? Weight_Nums : Output_Nums);
   localparam int CW = $clog2(MAX_N + Pipeline_Tail + Output_Nums + 4) + 1;
   localparam int OW = $clog2(Output_Nums) + 1;
   localparam int WW = $clog2(Weight_Nums) + 1;

   localparam logic [CW-1:0] W_N       = CW'(Weight_Nums);
   localparam logic [CW-1:0] I_N       = CW'(Input_Nums);
   localparam logic [CW-1:0] O_N       = CW'(Output_Nums);
   localparam logic [CW-1:0] TWO       = CW'(2);
   localparam logic [CW-1:0] FILE_LAST = CW'(MAX_N - 1);
   localparam logic [CW-1:0] FILL_LAST = CW'(MAX_N + 1);
   localparam logic [CW-1:0] TAIL_LAST = CW'(Pipeline_Tail - 1);
   localparam logic [CW-1:0] WB_LAST   = CW'(Output_Nums - 1);
   localparam logic [OW-1:0] O_LAST    = OW'(Output_Nums - 1);
   localparam logic [WW-1:0] W_LAST    = WW'(Weight_Nums - 1);

   typedef enum logic [2:0] {S_IDLE, S_FILE, S_FILL, S_COMP, S_DRAIN, S_WB, S_FIN} state_t;

   state_t        state, ns;
   logic [CW-1:0] cnt, ncnt;
   logic [OW-1:0] o, no;
   logic [WW-1:0] w, nw;
   logic          pre, npre;

   always_comb begin
      ns   = state;
      ncnt = cnt;
      no   = o;
      nw   = w;
      npre = pre;
      case (state)
         S_IDLE: if (Start) begin
            ns   = S_FILE;
            ncnt = '0;
            no   = '0;
            nw   = '0;
            npre = Preload_Output;
         end
         S_FILE: if (cnt == FILE_LAST) begin ns = S_FILL; ncnt = '0; end
                 else ncnt = cnt + CW'(1);
         S_FILL: if (cnt == FILL_LAST) begin ns = S_COMP; ncnt = '0; end
                 else ncnt = cnt + CW'(1);
         // o/w freeze on the last tap so DRAIN keeps presenting the final indices
         S_COMP: if (w == W_LAST) begin
            if (o == O_LAST) begin ns = S_DRAIN; ncnt = '0; end
            else begin nw = '0; no = o + OW'(1); end
         end else nw = w + WW'(1);
         S_DRAIN: if (cnt == TAIL_LAST) begin ns = S_WB; ncnt = '0; end
                  else ncnt = cnt + CW'(1);
         S_WB: if (cnt == WB_LAST) begin ns = S_FIN; ncnt = '0; end
               else ncnt = cnt + CW'(1);
         S_FIN:   ns = S_IDLE;
         default: ns = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt <= '0; o <= '0; w <= '0; pre <= 1'b0;
         Weight_Loading_From_File <= 1'b0; Input_Loading_From_File <= 1'b0;
         Output_Loading_From_File <= 1'b0; Output_Writing_To_File <= 1'b0;
         Mem_Weight_Index <= '0; Mem_Input_Index <= '0; Mem_Output_Index <= '0;
         L0_Weight_Index <= '0; L0_Input_Index <= '0; L0_Output_Index <= '0;
         L0_Weight_Status <= 2'b00; L0_Input_Status <= 2'b00; L0_Output_Status <= 2'b00;
         L0_Data_Is_Ready <= 1'b0; Busy <= 1'b0; Done <= 1'b0;
      end else begin
         state <= ns; cnt <= ncnt; o <= no; w <= nw; pre <= npre;
         Weight_Loading_From_File <= 1'b0; Input_Loading_From_File <= 1'b0;
         Output_Loading_From_File <= 1'b0; Output_Writing_To_File <= 1'b0;
         Mem_Weight_Index <= '0; Mem_Input_Index <= '0; Mem_Output_Index <= '0;
         L0_Weight_Index <= '0; L0_Input_Index <= '0; L0_Output_Index <= '0;
         L0_Weight_Status <= 2'b00; L0_Input_Status <= 2'b00; L0_Output_Status <= 2'b00;
         L0_Data_Is_Ready <= 1'b0;
         Busy <= (ns != S_IDLE) && (ns != S_FIN);
         Done <= (ns == S_FIN);
         case (ns)
            S_FILE: begin
               Weight_Loading_From_File <= (ncnt < W_N);
               Input_Loading_From_File  <= (ncnt < I_N);
               Output_Loading_From_File <= npre && (ncnt < O_N);
               Mem_Weight_Index <= (ncnt < W_N) ? MW'(ncnt) : '0;
               Mem_Input_Index  <= (ncnt < I_N) ? MI'(ncnt) : '0;
               Mem_Output_Index <= (ncnt < O_N) ? MO'(ncnt) : '0;
            end
            // Mem index leads the L0 index by 2 to cover SRAM read latency plus one register
            S_FILL: begin
               if (ncnt < W_N + TWO) begin
                  L0_Weight_Status <= 2'b01;
                  Mem_Weight_Index <= MW'(ncnt + TWO);
                  L0_Weight_Index  <= (ncnt < TWO) ? '0 : LW'(ncnt - TWO);
               end else L0_Weight_Status <= 2'b10;
               if (ncnt < I_N + TWO) begin
                  L0_Input_Status <= 2'b01;
                  Mem_Input_Index <= MI'(ncnt + TWO);
                  L0_Input_Index  <= (ncnt < TWO) ? '0 : LI'(ncnt - TWO);
               end else L0_Input_Status <= 2'b10;
               if (ncnt < O_N + TWO) begin
                  L0_Output_Status <= 2'b01;
                  Mem_Output_Index <= MO'(ncnt + TWO);
                  L0_Output_Index  <= (ncnt < TWO) ? '0 : LO'(ncnt - TWO);
               end else L0_Output_Status <= 2'b10;
            end
            S_COMP, S_DRAIN: begin
               L0_Weight_Status <= 2'b10; L0_Input_Status <= 2'b10; L0_Output_Status <= 2'b10;
               L0_Weight_Index  <= LW'(nw);
               L0_Input_Index   <= LI'(no) + LI'(nw);
               L0_Output_Index  <= LO'(no);
               L0_Data_Is_Ready <= (ns == S_COMP);
            end
            S_WB: begin
               L0_Weight_Status <= 2'b10; L0_Input_Status <= 2'b10;
               Output_Writing_To_File <= 1'b1;
               Mem_Output_Index <= MO'(ncnt);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_conv1d_index_sequencer.sv
// Randomized job sequences compared cycle by cycle against a phase-table model of the sequencer.
module tb_conv1d_index_sequencer;
   localparam int WN = 4, ON = 8, IN = 11, TAIL = 3;

   logic clk = 1'b0, rst_n = 1'b0, Start = 1'b0, Preload_Output = 1'b0;
   logic wl, il, ol, wr, rdy, busy, done;
   logic [2:0] mw; logic [4:0] mi; logic [3:0] mo;
   logic [2:0] lw; logic [4:0] li; logic [3:0] lo;
   logic [1:0] sw, si, so;

   typedef struct packed {
      logic wl, il, ol, wr;
      logic [2:0] mw; logic [4:0] mi; logic [3:0] mo;
      logic [2:0] lw; logic [4:0] li; logic [3:0] lo;
      logic [1:0] sw, si, so;
      logic rdy, busy, done;
   } vec_t;

   vec_t obs;
   assign obs = {wl, il, ol, wr, mw, mi, mo, lw, li, lo, sw, si, so, rdy, busy, done};

   vec_t exp_q[$];
   vec_t msk_q[$];
   int n_chk = 0, n_pass = 0;

   conv1d_index_sequencer dut (
      .clk(clk), .rst_n(rst_n), .Start(Start), .Preload_Output(Preload_Output),
      .Weight_Loading_From_File(wl), .Input_Loading_From_File(il),
      .Output_Loading_From_File(ol), .Output_Writing_To_File(wr),
      .Mem_Weight_Index(mw), .Mem_Input_Index(mi), .Mem_Output_Index(mo),
      .L0_Weight_Index(lw), .L0_Input_Index(li), .L0_Output_Index(lo),
      .L0_Weight_Status(sw), .L0_Input_Status(si), .L0_Output_Status(so),
      .L0_Data_Is_Ready(rdy), .Busy(busy), .Done(done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_chk++;
      if (got === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, expv);
   endtask

   // Expected per-cycle outputs for one job, built phase by phase.
   task automatic build_job(input bit pre);
      vec_t e, m;
      int fl, depth[3];
      exp_q.delete(); msk_q.delete();
      fl = (IN > WN) ? IN : WN; fl = (ON > fl) ? ON : fl;
      depth = '{WN, IN, ON};
      for (int f = 0; f < fl; f++) begin
         e = '0; m = '1; e.busy = 1'b1;
         e.wl = (f < WN); e.il = (f < IN); e.ol = pre && (f < ON);
         e.mw = (f < WN) ? 3'(f) : 3'd0;
         e.mi = (f < IN) ? 5'(f) : 5'd0;
         e.mo = (f < ON) ? 4'(f) : 4'd0;
         if (!pre) m.mo = '0;
         exp_q.push_back(e); msk_q.push_back(m);
      end
      for (int k = 0; k < fl + 2; k++) begin
         e = '0; m = '1; e.busy = 1'b1;
         if (k < depth[0] + 2) begin e.sw = 2'b01; e.mw = 3'(k + 2); e.lw = (k < 2) ? 3'd0 : 3'(k - 2); end
         else e.sw = 2'b10;
         if (k < depth[1] + 2) begin e.si = 2'b01; e.mi = 5'(k + 2); e.li = (k < 2) ? 5'd0 : 5'(k - 2); end
         else e.si = 2'b10;
         if (k < depth[2] + 2) begin e.so = 2'b01; e.mo = 4'(k + 2); e.lo = (k < 2) ? 4'd0 : 4'(k - 2); end
         else e.so = 2'b10;
         exp_q.push_back(e); msk_q.push_back(m);
      end
      for (int o = 0; o < ON; o++)
         for (int w = 0; w < WN; w++) begin
            e = '0; m = '1; e.busy = 1'b1; e.rdy = 1'b1;
            e.sw = 2'b10; e.si = 2'b10; e.so = 2'b10;
            e.lw = 3'(w); e.li = 5'(o + w); e.lo = 4'(o);
            exp_q.push_back(e); msk_q.push_back(m);
         end
      for (int d = 0; d < TAIL; d++) begin
         e = '0; m = '1; e.busy = 1'b1;
         e.sw = 2'b10; e.si = 2'b10; e.so = 2'b10;
         e.lw = 3'(WN - 1); e.li = 5'(ON + WN - 2); e.lo = 4'(ON - 1);
         exp_q.push_back(e); msk_q.push_back(m);
      end
      for (int i = 0; i < ON; i++) begin
         e = '0; m = '1; e.busy = 1'b1; e.wr = 1'b1;
         e.mo = 4'(i); e.sw = 2'b10; e.si = 2'b10;
         m.lw = '0; m.li = '0; m.lo = '0;
         exp_q.push_back(e); msk_q.push_back(m);
      end
      e = '0; m = '1; e.done = 1'b1;
      exp_q.push_back(e); msk_q.push_back(m);
   endtask

   // Entered and left at a falling edge; abort_at>0 pulls reset after that cycle's compare.
   task automatic run_job(input bit pre, input int abort_at, input int j);
      int n;
      build_job(pre);
      n = exp_q.size();
      Start = 1'b1; Preload_Output = pre;
      @(posedge clk);
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         check_val($sformatf("job%0d_cyc%0d", j, c), 64'(obs & msk_q[c-1]), 64'(exp_q[c-1] & msk_q[c-1]));
         Start = (c == n) || ($urandom_range(0, 5) == 0);
         Preload_Output = 1'($urandom_range(0, 1));
         if (c == abort_at) begin
            #1 rst_n = 1'b0; Start = 1'b0;
            #1 check_val($sformatf("job%0d_async_rst", j), 64'(obs), 64'd0);
            @(negedge clk);
            check_val($sformatf("job%0d_rst_hold", j), 64'(obs), 64'd0);
            rst_n = 1'b1;
            return;
         end
      end
      @(negedge clk);
      Start = 1'b0;
      check_val($sformatf("job%0d_idle_after_fin", j), 64'(obs), 64'd0);
   endtask

   task automatic idle_gap(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check_val("idle", 64'(obs), 64'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_val("reset_state", 64'(obs), 64'd0);
      rst_n = 1'b1;
      idle_gap(1);
      run_job(1'b1, 0, 0);
      idle_gap($urandom_range(0, 3));
      run_job(1'b0, 0, 1);
      idle_gap($urandom_range(0, 3));
      run_job(1'b1, 39, 2);
      idle_gap($urandom_range(0, 3));
      for (int j = 3; j < 8; j++) begin
         run_job(1'($urandom_range(0, 1)), 0, j);
         idle_gap($urandom_range(0, 3));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
